// File: rtl/vga_sync_gen.sv
// 640x480@60 Hz VGA raster generator: pixel counters, active-low syncs, display enable
// and a completed-frame counter. Every output is registered off the same next position.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        display_on,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic [9:0]  HLast    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  VLast    = 10'(V_TOTAL - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : gen_bad_totals
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        display_on_q, display_on_d;
  logic        line_start_q, line_start_d, frame_start_q, frame_start_d;

  always_comb begin
    x_d           = x_q + 10'd1;
    y_d           = y_q;
    frame_count_d = frame_count_q;
    if (x_q == HLast) begin
      x_d = '0;
      if (y_q == VLast) begin
        y_d           = '0;
        frame_count_d = frame_count_q + 16'd1;
      end else begin
        y_d = y_q + 10'd1;
      end
    end
  end

  // Decode the position being entered so the flags land on the same edge as x/y.
  always_comb begin
    hsync_d       = !((32'(x_d) >= HS_START) && (32'(x_d) < HS_END));
    vsync_d       = !((32'(y_d) >= VS_START) && (32'(y_d) < VS_END));
    display_on_d  = (32'(x_d) < H_VISIBLE) && (32'(y_d) < V_VISIBLE);
    line_start_d  = (x_d == '0);
    frame_start_d = (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_count_q <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      display_on_q  <= 1'b1;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else if (en) begin
      x_q           <= x_d;
      y_q           <= y_d;
      frame_count_q <= frame_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = display_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size raster for horizontal timing, a shrunken raster (16x12) for
// vertical, frame and reset-in-vsync behaviour so whole frames fit in a short run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, rst_s, en_s;
  logic [9:0]  x, y, s_x, s_y;
  logic        hsync, vsync, display_on, line_start, frame_start;
  logic        s_hsync, s_vsync, s_display_on, s_line_start, s_frame_start;
  logic [15:0] frame_count, s_frame_count;

  int n_checks = 0;
  int n_errors = 0;

  vga_sync_gen u_dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .x           (x),
    .y           (y),
    .hsync       (hsync),
    .vsync       (vsync),
    .display_on  (display_on),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  // Small raster: H 8+2+3+3=16 (hsync low x 10..12), V 6+2+2+2=12 (vsync low y 8..9).
  vga_sync_gen #(
    .H_VISIBLE (8),
    .H_FRONT   (2),
    .H_SYNC    (3),
    .H_BACK    (3),
    .V_VISIBLE (6),
    .V_FRONT   (2),
    .V_SYNC    (2),
    .V_BACK    (2)
  ) u_dut_small (
    .clk         (clk),
    .rst         (rst_s),
    .en          (en_s),
    .x           (s_x),
    .y           (s_y),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .display_on  (s_display_on),
    .line_start  (s_line_start),
    .frame_start (s_frame_start),
    .frame_count (s_frame_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic advance(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int cnt, fs_cnt, rises, first_fall, low_first, bad;
  int rise_at [4];
  logic prev;

  initial begin
    rst = 1'b0; rst_s = 1'b0; en = 1'b0; en_s = 1'b0;
    #2;
    rst = 1'b1; rst_s = 1'b1;
    #1;
    check("rst_x", 32'(x), 0);
    check("rst_fc", 32'(frame_count), 0);
    advance(2);
    rst = 1'b0;
    en  = 1'b1;
    advance(37);
    check("pre_rst_x", 32'(x), 37);
    // Asynchronous reset mid-line, sampled before any clock edge.
    rst = 1'b1;
    #1;
    check("arst_x", 32'(x), 0);
    check("arst_y", 32'(y), 0);
    check("arst_hsync", 32'(hsync), 1);
    check("arst_vsync", 32'(vsync), 1);
    check("arst_disp", 32'(display_on), 1);
    check("arst_lstart", 32'(line_start), 1);
    check("arst_fstart", 32'(frame_start), 1);
    check("arst_fc", 32'(frame_count), 0);
    #1;
    rst = 1'b0;

    // Horizontal timing on the full-size raster.
    advance(639);
    check("h639_x", 32'(x), 639);
    check("h639_disp", 32'(display_on), 1);
    check("h639_lstart", 32'(line_start), 0);
    advance(1);
    check("h640_disp", 32'(display_on), 0);
    check("h640_hsync", 32'(hsync), 1);
    advance(15);
    check("h655_x", 32'(x), 655);
    check("h655_hsync", 32'(hsync), 1);
    en = 1'b0;
    advance(50);
    check("gate_x", 32'(x), 655);
    check("gate_hsync", 32'(hsync), 1);
    check("gate_disp", 32'(display_on), 0);
    check("gate_y", 32'(y), 0);
    en = 1'b1;
    advance(1);
    check("h656_x", 32'(x), 656);
    check("h656_hsync", 32'(hsync), 0);
    cnt = 0;
    while (hsync == 1'b0 && cnt < 2000) begin
      advance(1);
      cnt++;
    end
    check("hsync_width", 32'(cnt), 96);
    check("hsync_rise_x", 32'(x), 752);
    advance(47);
    check("h799_x", 32'(x), 799);
    check("h799_disp", 32'(display_on), 0);
    advance(1);
    check("hwrap_x", 32'(x), 0);
    check("hwrap_y", 32'(y), 1);
    check("hwrap_lstart", 32'(line_start), 1);
    check("hwrap_fstart", 32'(frame_start), 0);
    check("hwrap_disp", 32'(display_on), 1);
    en = 1'b0;

    // Vertical and frame behaviour on the small raster (frame = 192 cycles).
    rst_s = 1'b0;
    en_s  = 1'b1;
    fs_cnt = s_frame_start ? 1 : 0;
    rises = 0; first_fall = -1; low_first = 0; bad = 0;
    prev = s_vsync;
    for (int c = 1; c <= 576; c++) begin
      advance(1);
      if (s_frame_start) fs_cnt++;
      if (!prev && s_vsync) begin
        if (rises < 4) rise_at[rises] = c;
        rises++;
      end
      if (prev && !s_vsync && first_fall < 0) begin
        first_fall = c;
        check("vfall_x", 32'(s_x), 0);
        check("vfall_y", 32'(s_y), 8);
      end
      if (c <= 192 && !s_vsync) low_first++;
      if (s_y >= 10'd6 && s_display_on) bad++;
      if (c == 191) begin
        check("vend_x", 32'(s_x), 15);
        check("vend_y", 32'(s_y), 11);
        check("vend_fc", 32'(s_frame_count), 0);
      end
      if (c == 192) begin
        check("vwrap_xy", {6'd0, s_y, 6'd0, s_x}, 0);
        check("vwrap_fc", 32'(s_frame_count), 1);
        check("vwrap_fstart", 32'(s_frame_start), 1);
      end
      prev = s_vsync;
    end
    check("fstart_count", 32'(fs_cnt), 4);
    check("vrise_count", 32'(rises), 3);
    check("vrise0_at", 32'(rise_at[0]), 160);
    check("vrise_gap1", 32'(rise_at[1] - rise_at[0]), 192);
    check("vrise_gap2", 32'(rise_at[2] - rise_at[1]), 192);
    check("vfall_at", 32'(first_fall), 128);
    check("vsync_width", 32'(low_first), 32);
    check("vblank_disp", 32'(bad), 0);
    check("fc_3", 32'(s_frame_count), 3);

    // Reset during the vsync pulse, then time the next vsync fall.
    advance(130);
    check("mid_vs_y", 32'(s_y), 8);
    check("mid_vs_vsync", 32'(s_vsync), 0);
    rst_s = 1'b1;
    #1;
    check("vs_arst_vsync", 32'(s_vsync), 1);
    check("vs_arst_fc", 32'(s_frame_count), 0);
    #1;
    rst_s = 1'b0;
    cnt = 0;
    while (s_vsync == 1'b1 && cnt < 1000) begin
      advance(1);
      cnt++;
    end
    check("vs_after_rst", 32'(cnt), 128);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
